// File: rtl/vector_dot.sv
// vector_dot: serial signed Q16.16 dot product, one MAC per cycle.
// Ports: clk, rst(sync,high), start, length, Ain, Bin -> Dout, done, overflow.
module vector_dot #(
  parameter int FRAC_BITS = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         length,
  input  logic [191:0] Ain,
  input  logic [191:0] Bin,
  output logic [31:0]  Dout,
  output logic         done,
  output logic         overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_FINISH,
    S_DONE
  } state_t;

  localparam logic signed [66:0] MAXV =
    67'sh0_7FFF_FFFF;
  localparam logic signed [66:0] MINV =
    {{35{1'b1}}, 32'h8000_0000};

  state_t              r_state;
  logic [191:0]        r_a;
  logic [191:0]        r_b;
  logic [2:0]          r_n;
  logic [2:0]          r_k;
  logic signed [66:0]  r_acc;
  logic [31:0]         r_dout;
  logic                r_done;
  logic                r_ovf;

  logic [7:0]          w_sel;
  logic signed [31:0]  w_a;
  logic signed [31:0]  w_b;
  logic signed [63:0]  w_prod;
  logic signed [66:0]  w_r;

  // k selects the 32-bit lane; only k < N is ever used
  assign w_sel  = {r_k, 5'd0};
  assign w_a    = r_a[w_sel +: 32];
  assign w_b    = r_b[w_sel +: 32];
  assign w_prod = w_a * w_b;
  assign w_r    = r_acc >>> FRAC_BITS;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_k     <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= Ain;
            r_b     <= Bin;
            r_n     <= length ? 3'd6 : 3'd4;
            r_acc   <= '0;
            r_k     <= '0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + {{3{w_prod[63]}}, w_prod};
          r_k   <= r_k + 3'd1;
          if (r_k == r_n - 3'd1)
            r_state <= S_FINISH;
        end
        S_FINISH: begin
          // saturate once, after the full-precision sum
          if (w_r > MAXV) begin
            r_dout <= 32'h7FFF_FFFF;
            r_ovf  <= 1'b1;
          end else if (w_r < MINV) begin
            r_dout <= 32'h8000_0000;
            r_ovf  <= 1'b1;
          end else begin
            r_dout <= w_r[31:0];
            r_ovf  <= 1'b0;
          end
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (!start) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Dout     = r_dout;
  assign done     = r_done;
  assign overflow = r_ovf;

endmodule

// File: doc/vector_dot.md
# vector_dot

Serial fixed-point dot-product engine for the vector datapath. It consumes two packed 192-bit vectors of signed Q16.16 elements, such as the element-wise add/sub result alongside a weight vector. It produces one saturated signed 32-bit Q16.16 scalar. The block uses one multiplier, processes one element per cycle, and shares the level-start / held-done handshake used by the other vector stages so it chains directly after them.

## Interface

- FRAC_BITS, 16: fractional bits of the Q-format for inputs and output; the product shift amount.
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  level request. Sampled only in IDLE.
- length  input  1  vector length select: 0 = 4 elements, 1 = 6 elements. Captured with start.
- Ain  input  192  packed signed vector; element i at bits [32i+31:32i].
- Bin  input  192  packed signed vector, same packing.
- Dout  output  32  signed Q16.16 dot product, saturated. Registered.
- done  output  1  result valid; held while start stays high.
- overflow  output  1  set with done when Dout was saturated.

## Operation

- States: IDLE, MAC, FINISH, DONE.
- IDLE with start=1:
  - capture Ain, Bin into element registers A[0..5], B[0..5]
  - capture N = length ? 6 : 4
  - clear the 67-bit signed accumulator and element index k
  - next state is MAC.
- MAC: acc += A[k]*B[k], using the full 64-bit signed product (Q32.32).
  - k increments each cycle.
  - After element k = N-1, next state is FINISH.
  - Elements at index >= N are never read.
- FINISH:
  - r = acc >>> FRAC_BITS (arithmetic shift, floor rounding).
  - If r > 2^31-1, then Dout = 0x7FFFFFFF and overflow = 1.
  - If r < -2^31, then Dout = 0x80000000 and overflow = 1.
  - Otherwise Dout = r[31:0] and overflow = 0.
  - done <= 1. Next state is DONE.
- DONE:
  - done stays 1 while start=1.
  - When start=0, the next state is IDLE and done <= 0 on that edge.
- Accumulator width is 67 bits: 6 × 2^62 needs no intermediate wrap. Saturation is applied only once, at FINISH.
- Ain, Bin and length changes after the capture edge have no effect on the running operation.
- start is ignored in MAC and FINISH. It is also ignored in DONE, apart from its deassertion.
- Dout and overflow hold their last values until the next FINISH. They are not cleared by returning to IDLE.
- Reset, including mid-MAC: on the reset edge, state becomes IDLE and Dout, done, overflow, acc and k all become 0. The partial result is discarded. If start is still high after reset, a new operation begins on the first non-reset edge.

## Timing

- Let E0 be the edge that samples start=1 in IDLE.
- Edges E1..EN perform the accumulations.
- Edge E(N+1) registers Dout and overflow and sets done.
- done is visible after edge E5 for N=4 and after edge E7 for N=6.
- Minimum period between starts:
  - N+3 edges with start held through DONE: the fall of start returns to IDLE, and the next edge can sample a new start.
  - If start is dropped early, the block still finishes normally. It then spends one edge in DONE, with done high for one cycle, before returning to IDLE.
- Outputs update only on clk rising edges. There are no combinational paths from inputs to outputs.

## Test plan

- **Length 4, basic.** All A elements = 0x00010000 (1.0), all B elements = 0x00020000 (2.0), length=0; the upper two elements of both vectors are 0x7FFFFFFF.
  - Dout = 0x00080000, overflow = 0, done rises after edge E5.
  - The upper elements must not affect the result.
- **Length 6, mixed signs.** A = {1.0, -1.0, 2.0, -2.0, 0.5, 3.0}, B = {1.0, 1.0, 1.0, 1.0, 2.0, -1.0}.
  - Expected sum is 1 - 1 + 2 - 2 + 1 - 3 = -2.0, so Dout = 0xFFFE0000.
  - done rises after edge E7.
- **Saturation, both directions.** Length 6.
  - All A = B = 0x7FFFFFFF: Dout = 0x7FFFFFFF, overflow = 1.
  - A = 0x80000000, B = 0x7FFFFFFF in all elements: Dout = 0x80000000, overflow = 1.
- **Floor rounding.** A[0] = 0xFFFFFFFF, B[0] = 0x00000001, all other elements 0, length 4 → Dout = 0xFFFFFFFF, overflow = 0.
- **Handshake and back-to-back operation.**
  - Hold start for 10 cycles after done: done stays 1 and Dout is stable.
  - Drop start: done = 0 on the next edge.
  - Re-assert start with new operands one edge later: the second result is correct. Ain changes during MAC are ignored.
- **Reset mid-MAC.** Assert rst at edge E3 of a length-6 operation.
  - Dout, done and overflow are 0 after that edge, and state is IDLE.
  - A subsequent start produces the correct result with no residue from the aborted accumulation.
